wd1793_sector_loader: RTL and testbench
=======================================

// Module: wd1793_sector_loader
// PURPOSE
//   Workhorse stage feeding the WD1793 emulation core. Picks up the core's oCPU_REQUEST, reads the
//   addressed 1024-byte sector (or 6-byte ID field) from a linear disk image in external byte memory,
//   and copies it into the shared sector buffer. It then answers with the done/success status that
//   the core samples on iCPU_STATUS. Writes are refused: images are read-only.
// PARAMETERS
//   SECTOR_SIZE        1024  bytes per sector; buffer depth; must be a power of two
//   SECTORS_PER_TRACK  5     sectors per track side, numbered 1..SECTORS_PER_TRACK
//   TRACKS             80    tracks per side; track >= TRACKS fails
//   ADDR_W             20    image byte-address width
// PORTS
//   clk           in   1       system clock
//   reset_n       in   1       reset, asynchronous, active-low
//   clken         in   1       clock enable; all state advances only when high
//   iCPU_REQUEST  in   8       request code from core: [7:4] op (1 READ, 2 WRITE, 3 READADDR, 4 NOP, 8 ACK), [0] side
//   iTRACK        in   8       physical head track (core oTRACK)
//   iSECTOR       in   8       sector register (core oSECTOR)
//   img_ready     in   1       disk image mounted and memory usable
//   oCPU_STATUS   out  8       {6'b0, success, done} to core iCPU_STATUS
//   mem_addr      out  ADDR_W  image byte address
//   mem_rd        out  1       one-clken-cycle read strobe
//   mem_ack       in   1       read data valid on mem_idata; may arrive any number of cycles later
//   mem_idata     in   8       image byte
//   buff_addr     out  10      sector buffer write address
//   buff_wr       out  1       sector buffer write strobe, one clken cycle per byte
//   buff_odata    out  8       sector buffer write data
// BEHAVIOUR
//   Reset values: oCPU_STATUS=0, mem_addr=0, mem_rd=0, buff_addr=0, buff_wr=0, buff_odata=0, state IDLE.
//   States: IDLE, CALC, FETCH, WAITMEM, STORE, IDFILL, DONE.
//   IDLE: when iCPU_REQUEST[7:4] is not 8 (ACK) and not 0, latch op, side, track and sector.
//     READ -> CALC.
//     READADDR -> IDFILL (no image access).
//     NOP -> DONE with status 2'b11.
//     WRITE -> DONE with status 2'b01.
//     Any other code -> DONE with status 2'b01.
//   CALC (1 cycle): if !img_ready, track >= TRACKS, sector == 0, or sector > SECTORS_PER_TRACK,
//     go to DONE with status 2'b01. Otherwise set
//     mem_addr = (((track*2 + side)*SECTORS_PER_TRACK) + sector - 1) * SECTOR_SIZE,
//     truncated to ADDR_W bits; clear byte counter and go to FETCH.
//   FETCH: pulse mem_rd for 1 cycle, then WAITMEM.
//   WAITMEM: on mem_ack, buff_odata=mem_idata, buff_addr=byte counter, buff_wr=1, then STORE.
//   STORE: deassert buff_wr.
//     If byte counter == SECTOR_SIZE-1: DONE with status 2'b11.
//     Else increment byte counter and mem_addr, then FETCH.
//   IDFILL: write 6 bytes at buff_addr 0..5, one per clken cycle:
//     track, side, sector, size code 3, 0x00, 0x00 (CRC not modelled).
//     Then DONE with status 2'b11.
//   DONE: hold oCPU_STATUS until iCPU_REQUEST == ACK (0x80). Then clear status to 0 and go to IDLE.
//     This guarantees the core never sees a stale done bit on its next request.
//   Abort: iCPU_REQUEST becoming ACK in any state other than IDLE/DONE (core force interrupt):
//     go to IDLE next cycle, status 0, mem_rd=0, buff_wr=0.
//     An outstanding mem_ack arriving in IDLE is ignored.
//   Busy: done bit is 0 in every state except DONE.
//   Latency: READ takes at least 2 + 3*SECTOR_SIZE clken cycles with zero-wait memory (mem_ack in the cycle after mem_rd).
//     NOP takes 1 cycle to DONE.
//   Ordering: buffer writes are strictly ascending from address 0; the core never reads the buffer before done.
//   Reset asserted mid-operation: all outputs return to reset values immediately.
//     Any partially written buffer is simply overwritten by the next request.
// TESTING
//   1. READ side 0 track 0 sector 1, zero-wait memory -> mem_addr starts 0x00000.
//      1024 buff_wr strobes with addr 0..1023 and data matching image.
//      Status 0x03, cleared to 0 after ACK.
//   2. READ side 1 track 2 sector 5 -> first mem_addr = ((2*2+1)*5+4)*1024 = 0x07400; status 0x03.
//   3. READ sector 6, sector 0, track 80, or img_ready=0 -> no mem_rd, no buff_wr; status 0x01 within 2 cycles.
//   4. READADDR side 1 track 7 sector 3 -> buffer bytes 0..5 = 07 01 03 03 00 00; status 0x03.
//      NOP 0x40 -> status 0x03. WRITE 0x20 -> status 0x01.
//   5. ACK asserted after 100 bytes of a READ, with random mem_ack delays 0..7 -> IDLE.
//      No further buff_wr; status 0; next READ completes normally.
//   6. reset_n low mid-sector -> all outputs 0 asynchronously; after release, a new request works.

Source files
------------

// File: rtl/wd1793_sector_loader.sv
// Sector loader behind the WD1793 core: copies a sector or ID field from a
// read-only linear disk image into the shared sector buffer.
module wd1793_sector_loader #(
  parameter int SECTOR_SIZE       = 1024,
  parameter int SECTORS_PER_TRACK = 5,
  parameter int TRACKS            = 80,
  parameter int ADDR_W            = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic [7:0]        iCPU_REQUEST,
  input  logic [7:0]        iTRACK,
  input  logic [7:0]        iSECTOR,
  input  logic              img_ready,
  output logic [7:0]        oCPU_STATUS,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [7:0]        mem_idata,
  output logic [9:0]        buff_addr,
  output logic              buff_wr,
  output logic [7:0]        buff_odata
);

  localparam int CW = $clog2(SECTOR_SIZE);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CALC    = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_WAITMEM = 3'd3;
  localparam logic [2:0] S_STORE   = 3'd4;
  localparam logic [2:0] S_IDFILL  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_RADDR = 4'h3;
  localparam logic [3:0] OP_NOP   = 4'h4;
  localparam logic [3:0] OP_ACK   = 4'h8;

  logic [2:0]        state_q, state_d;
  logic              side_q, side_d;
  logic [7:0]        trk_q, trk_d;
  logic [7:0]        sec_q, sec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [1:0]        st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [9:0]        baddr_q, baddr_d;
  logic [7:0]        bdata_q, bdata_d;

  logic [3:0]  op_w;
  logic        abort_w;
  logic        bad_w;
  logic [31:0] lsec_w;
  logic [7:0]  idb_w;

  assign op_w = iCPU_REQUEST[7:4];

  // ACK outside IDLE/DONE is the core's force interrupt
  assign abort_w = (op_w == OP_ACK)
                && (state_q != S_IDLE)
                && (state_q != S_DONE);

  assign bad_w = !img_ready
              || (32'(trk_q) >= 32'(TRACKS))
              || (sec_q == 8'd0)
              || (32'(sec_q) > 32'(SECTORS_PER_TRACK));

  assign lsec_w = (32'(trk_q) * 32'd2 + 32'(side_q))
                * 32'(SECTORS_PER_TRACK)
                + 32'(sec_q) - 32'd1;

  always_comb begin
    case (idx_q)
      3'd0:    idb_w = trk_q;
      3'd1:    idb_w = {7'd0, side_q};
      3'd2:    idb_w = sec_q;
      3'd3:    idb_w = 8'd3;
      default: idb_w = 8'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    trk_d   = trk_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    st_d    = st_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    baddr_d = baddr_q;
    bdata_d = bdata_q;
    if (abort_w) begin
      state_d = S_IDLE;
      st_d    = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_w != OP_ACK && op_w != 4'h0) begin
            side_d = iCPU_REQUEST[0];
            trk_d  = iTRACK;
            sec_d  = iSECTOR;
            unique case (1'b1)
              (op_w == OP_READ): state_d = S_CALC;
              (op_w == OP_RADDR): begin
                state_d = S_IDFILL;
                idx_d   = 3'd0;
              end
              (op_w == OP_NOP): begin
                state_d = S_DONE;
                st_d    = 2'b11;
              end
              default: begin
                state_d = S_DONE;
                st_d    = 2'b01;
              end
            endcase
          end
        end
        S_CALC: begin
          if (bad_w) begin
            state_d = S_DONE;
            st_d    = 2'b01;
          end else begin
            addr_d  = ADDR_W'(lsec_w * 32'(SECTOR_SIZE));
            cnt_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          rd_d    = 1'b1;
          state_d = S_WAITMEM;
        end
        S_WAITMEM: begin
          if (mem_ack) begin
            bdata_d = mem_idata;
            baddr_d = 10'(cnt_q);
            wr_d    = 1'b1;
            state_d = S_STORE;
          end
        end
        S_STORE: begin
          if (cnt_q == CW'(SECTOR_SIZE - 1)) begin
            state_d = S_DONE;
            st_d    = 2'b11;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
        S_IDFILL: begin
          // idx 6 is a spare cycle so the last strobe drops before done
          if (idx_q == 3'd6) begin
            state_d = S_DONE;
            st_d    = 2'b11;
          end else begin
            wr_d    = 1'b1;
            baddr_d = 10'(idx_q);
            bdata_d = idb_w;
            idx_d   = idx_q + 3'd1;
          end
        end
        S_DONE: begin
          if (iCPU_REQUEST == 8'h80) begin
            state_d = S_IDLE;
            st_d    = 2'b00;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      side_q  <= 1'b0;
      trk_q   <= '0;
      sec_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      st_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      baddr_q <= '0;
      bdata_q <= '0;
    end else if (clken) begin
      state_q <= state_d;
      side_q  <= side_d;
      trk_q   <= trk_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      baddr_q <= baddr_d;
      bdata_q <= bdata_d;
    end
  end

  assign oCPU_STATUS = {6'd0, st_q};
  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign buff_addr   = baddr_q;
  assign buff_wr     = wr_q;
  assign buff_odata  = bdata_q;

endmodule

// File: tb/tb_wd1793_sector_loader.sv
// Directed bench for wd1793_sector_loader: image memory model with optional
// random ack delay and a buffer write monitor.
module tb_wd1793_sector_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b1;
  logic [7:0]  iCPU_REQUEST = 8'h00;
  logic [7:0]  iTRACK = 8'h00;
  logic [7:0]  iSECTOR = 8'h00;
  logic        img_ready = 1'b1;
  logic [7:0]  oCPU_STATUS;
  logic [19:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_idata = 8'h00;
  logic [9:0]  buff_addr;
  logic        buff_wr;
  logic [7:0]  buff_odata;

  wd1793_sector_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clken        (clken),
    .iCPU_REQUEST (iCPU_REQUEST),
    .iTRACK       (iTRACK),
    .iSECTOR      (iSECTOR),
    .img_ready    (img_ready),
    .oCPU_STATUS  (oCPU_STATUS),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_ack      (mem_ack),
    .mem_idata    (mem_idata),
    .buff_addr    (buff_addr),
    .buff_wr      (buff_wr),
    .buff_odata   (buff_odata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] img(input logic [19:0] a);
    return a[7:0] ^ a[17:10] ^ 8'hA5;
  endfunction

  // image memory
  bit          rnd = 1'b0;
  logic [2:0]  mcnt = 3'd0;
  logic [2:0]  dnext = 3'd0;
  logic [19:0] pa = 20'd0;

  always @(posedge clk) begin
    dnext   <= rnd ? 3'($urandom_range(0, 7)) : 3'd0;
    mem_ack <= 1'b0;
    if (mcnt != 3'd0) begin
      mcnt <= mcnt - 3'd1;
      if (mcnt == 3'd1) begin
        mem_ack   <= 1'b1;
        mem_idata <= img(pa);
      end
    end else if (mem_rd) begin
      pa <= mem_addr;
      if (dnext == 3'd0) begin
        mem_ack   <= 1'b1;
        mem_idata <= img(mem_addr);
      end else begin
        mcnt <= dnext;
      end
    end
  end

  // buffer / read monitor
  logic [7:0]  tbuf [0:1023];
  int          wcnt = 0;
  int          rcnt = 0;
  int          ord_err = 0;
  int          wbase = 0;
  int          rbase = 0;
  logic [19:0] first_addr = 20'd0;

  always @(posedge clk) begin
    if (clken) begin
      if (buff_wr) begin
        tbuf[buff_addr] <= buff_odata;
        wcnt <= wcnt + 1;
        if (buff_addr !== 10'(wcnt - wbase)) ord_err <= ord_err + 1;
      end
      if (mem_rd) begin
        if (rcnt == rbase) first_addr <= mem_addr;
        rcnt <= rcnt + 1;
      end
    end
  end

  task automatic start(input logic [7:0] req, input logic [7:0] trk,
                       input logic [7:0] sec);
    @(negedge clk);
    wbase = wcnt;
    rbase = rcnt;
    iTRACK = trk;
    iSECTOR = sec;
    iCPU_REQUEST = req;
  endtask

  task automatic wait_done(input string t, input int max, output int cyc);
    cyc = 0;
    while (cyc < max && oCPU_STATUS[0] !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    chk({t, "_done"}, 48'(oCPU_STATUS[0]), 48'd1);
  endtask

  task automatic do_ack(input string t);
    @(negedge clk);
    iCPU_REQUEST = 8'h80;
    @(negedge clk);
    chk({t, "_clr"}, 48'(oCPU_STATUS), 48'd0);
    iCPU_REQUEST = 8'h00;
  endtask

  task automatic chk_sector(input string t, input logic [19:0] base);
    int nbad;
    nbad = 0;
    chk({t, "_addr"}, 48'(first_addr), 48'(base));
    chk({t, "_nwr"}, 48'(wcnt - wbase), 48'd1024);
    chk({t, "_nrd"}, 48'(rcnt - rbase), 48'd1024);
    for (int i = 0; i < 1024; i++)
      if (tbuf[i] !== img(base + 20'(i))) nbad++;
    chk({t, "_data"}, 48'(nbad), 48'd0);
    chk({t, "_order"}, 48'(ord_err), 48'd0);
  endtask

  task automatic fail_case(input string t, input logic [7:0] req,
                           input logic [7:0] trk, input logic [7:0] sec,
                           input logic rdy);
    int cyc;
    img_ready = rdy;
    start(req, trk, sec);
    wait_done(t, 2, cyc);
    chk({t, "_st"}, 48'(oCPU_STATUS), 48'h01);
    chk({t, "_io"}, 48'((rcnt - rbase) + (wcnt - wbase)), 48'd0);
    do_ack(t);
    img_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    int n;

    repeat (2) @(negedge clk);
    chk("rst_status", 48'(oCPU_STATUS), 48'd0);
    chk("rst_io", 48'({mem_addr, mem_rd, buff_addr, buff_wr, buff_odata}),
        48'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // sector 1 of track 0 side 0 at image offset 0
    start(8'h10, 8'd0, 8'd1);
    wait_done("t1", 5000, cyc);
    chk("t1_st", 48'(oCPU_STATUS), 48'h03);
    chk("t1_lat", 48'(cyc >= 3074), 48'd1);
    chk_sector("t1", 20'h00000);
    chk("t1_b0", 48'(tbuf[0]), 48'hA5);
    chk("t1_b1023", 48'(tbuf[1023]), 48'h5A);
    do_ack("t1");

    start(8'h11, 8'd2, 8'd5);
    wait_done("t2", 5000, cyc);
    chk("t2_st", 48'(oCPU_STATUS), 48'h03);
    chk_sector("t2", 20'h07400);
    chk("t2_b1023", 48'(tbuf[1023]), 48'h47);
    do_ack("t2");

    // last valid sector of the image
    start(8'h11, 8'd79, 8'd5);
    wait_done("tmax", 5000, cyc);
    chk("tmax_st", 48'(oCPU_STATUS), 48'h03);
    chk_sector("tmax", 20'hC7C00);
    do_ack("tmax");

    fail_case("sec6", 8'h10, 8'd0, 8'd6, 1'b1);
    fail_case("sec0", 8'h10, 8'd0, 8'd0, 1'b1);
    fail_case("trk80", 8'h10, 8'd80, 8'd1, 1'b1);
    fail_case("noimg", 8'h10, 8'd0, 8'd1, 1'b0);

    start(8'h31, 8'd7, 8'd3);
    wait_done("raddr", 20, cyc);
    chk("raddr_st", 48'(oCPU_STATUS), 48'h03);
    chk("raddr_buf", {tbuf[0], tbuf[1], tbuf[2], tbuf[3], tbuf[4], tbuf[5]},
        48'h070103030000);
    chk("raddr_nwr", 48'(wcnt - wbase), 48'd6);
    chk("raddr_nrd", 48'(rcnt - rbase), 48'd0);
    do_ack("raddr");

    start(8'h40, 8'd0, 8'd0);
    wait_done("nop", 1, cyc);
    chk("nop_st", 48'(oCPU_STATUS), 48'h03);
    do_ack("nop");

    start(8'h20, 8'd0, 8'd1);
    wait_done("write", 1, cyc);
    chk("write_st", 48'(oCPU_STATUS), 48'h01);
    do_ack("write");

    start(8'h50, 8'd0, 8'd1);
    wait_done("badop", 1, cyc);
    chk("badop_st", 48'(oCPU_STATUS), 48'h01);
    do_ack("badop");

    // clock enable low freezes the FSM
    @(negedge clk);
    clken = 1'b0;
    start(8'h40, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("hold_st", 48'(oCPU_STATUS), 48'd0);
    clken = 1'b1;
    wait_done("hold", 1, cyc);
    chk("hold_st2", 48'(oCPU_STATUS), 48'h03);
    do_ack("hold");

    // force interrupt while byte 100 is outstanding
    rnd = 1'b1;
    start(8'h10, 8'd1, 8'd2);
    n = 0;
    while ((rcnt - rbase) < 101 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", 48'((rcnt - rbase) >= 101), 48'd1);
    iCPU_REQUEST = 8'h80;
    @(negedge clk);
    chk("abort_st", 48'(oCPU_STATUS), 48'd0);
    chk("abort_strb", 48'({mem_rd, buff_wr}), 48'd0);
    repeat (20) @(negedge clk);
    chk("abort_nwr", 48'(wcnt - wbase), 48'd100);
    chk("abort_nrd", 48'(rcnt - rbase), 48'd101);
    chk("abort_st2", 48'(oCPU_STATUS), 48'd0);
    iCPU_REQUEST = 8'h00;

    start(8'h10, 8'd3, 8'd4);
    wait_done("t5", 15000, cyc);
    chk("t5_st", 48'(oCPU_STATUS), 48'h03);
    chk_sector("t5", 20'h08400);
    do_ack("t5");
    rnd = 1'b0;

    // asynchronous reset in the middle of a sector
    start(8'h10, 8'd0, 8'd2);
    n = 0;
    while ((wcnt - wbase) < 300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach", 48'((wcnt - wbase) >= 300), 48'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    iCPU_REQUEST = 8'h00;
    #1;
    chk("arst_status", 48'(oCPU_STATUS), 48'd0);
    chk("arst_addr", 48'(mem_addr), 48'd0);
    chk("arst_strb", 48'({mem_rd, buff_wr}), 48'd0);
    chk("arst_buf", 48'({buff_addr, buff_odata}), 48'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    start(8'h10, 8'd0, 8'd3);
    wait_done("t6", 5000, cyc);
    chk("t6_st", 48'(oCPU_STATUS), 48'h03);
    chk_sector("t6", 20'h00800);
    do_ack("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
